// File: rtl/div_issue_ctrl_pkg.sv
// rtl/div_issue_ctrl_pkg.sv - shared op/state encodings and special-case constants for the divide sequencer
package div_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_BUSY   = 2'd2,
    S_HOLD   = 2'd3
  } state_e;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

endpackage

// File: rtl/div_fastpath_detect.sv
// rtl/div_fastpath_detect.sv - combinational detector for divides whose result is known without the divider
// Covers divide-by-zero and the signed INT_MIN / -1 overflow.
module div_fastpath_detect
  import div_issue_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            hit_o,
  output logic [XLEN-1:0] result_o
);

  logic signed_op;
  logic is_rem;

  always_comb begin
    hit_o     = 1'b0;
    result_o  = '0;
    signed_op = (op_i == OP_DIV) || (op_i == OP_REM);
    is_rem    = op_i[1];
    if (b_i == '0) begin
      hit_o    = 1'b1;
      result_o = is_rem ? a_i : DIV_ZERO_Q;
    end else if (signed_op && (a_i == INT_MIN) && (b_i == '1)) begin
      hit_o    = 1'b1;
      result_o = is_rem ? '0 : INT_MIN;
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - EX-stage multi-cycle divide sequencer with watchdog and EX->MEM slot insertion
// Optional feature macro: DIV_FASTPATH_EN (resolve divide-by-zero / signed overflow without the divider).
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DIV_LATENCY = 8,
  parameter int MAX_WAIT    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      req_op_i,
  input  logic [XLEN-1:0] req_a_i,
  input  logic [XLEN-1:0] req_b_i,
  input  logic [4:0]      req_rd_i,
  input  logic [XLEN-1:0] req_pc_i,
  input  logic [XLEN-1:0] req_inst_i,
  output logic            div_start_o,
  output logic [1:0]      div_op_o,
  output logic [XLEN-1:0] div_a_o,
  output logic [XLEN-1:0] div_b_o,
  input  logic            div_done_i,
  input  logic [XLEN-1:0] div_result_i,
  input  logic            alu_slot_i,
  output logic            wb_valid_o,
  output logic [4:0]      wb_rd_o,
  output logic [XLEN-1:0] wb_result_o,
  output logic [XLEN-1:0] wb_pc_o,
  output logic [XLEN-1:0] wb_inst_o,
  output logic            stall_o,
  output logic            busy_o,
  output logic [4:0]      busy_rd_o,
  output logic            err_o
);

  // A watchdog shorter than the nominal divide would always fire; keep it beyond DIV_LATENCY.
  localparam int WD_LIMIT = (MAX_WAIT > DIV_LATENCY) ? MAX_WAIT : DIV_LATENCY + 1;
  localparam int CW = (WD_LIMIT > 2) ? $clog2(WD_LIMIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WD_LIMIT - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] pc_q, pc_d, inst_q, inst_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            err_q, err_d;

  logic            fast_hit;
  logic [XLEN-1:0] fast_res;

`ifdef DIV_FASTPATH_EN
  div_fastpath_detect #(.XLEN(XLEN)) u_fastpath (
    .op_i     (req_op_i),
    .a_i      (req_a_i),
    .b_i      (req_b_i),
    .hit_o    (fast_hit),
    .result_o (fast_res)
  );
`else
  assign fast_hit = 1'b0;
  assign fast_res = '0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    rd_d        = rd_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    res_d       = res_q;
    err_d       = err_q;
    req_ready_o = 1'b0;
    div_start_o = 1'b0;
    wb_valid_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          op_d   = req_op_i;
          a_d    = req_a_i;
          b_d    = req_b_i;
          rd_d   = req_rd_i;
          pc_d   = req_pc_i;
          inst_d = req_inst_i;
          if (fast_hit) begin
            res_d   = fast_res;
            state_d = S_HOLD;
          end else begin
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        div_start_o = 1'b1;
        cnt_d       = '0;
        state_d     = S_BUSY;
      end
      S_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // A done in the watchdog's last cycle still counts as a real result.
        if (div_done_i) begin
          if (rd_q == 5'd0) begin
            state_d = S_IDLE;
          end else begin
            res_d   = div_result_i;
            state_d = S_HOLD;
          end
        end else if (cnt_q == CNT_LAST) begin
          res_d   = DIV_ZERO_Q;
          err_d   = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        wb_valid_o = ~alu_slot_i;
        if (!alu_slot_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      pc_q    <= '0;
      inst_q  <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign stall_o     = busy_o | (req_valid_i & req_ready_o);
  assign busy_rd_o   = busy_o ? rd_q : 5'd0;
  assign div_op_o    = op_q;
  assign div_a_o     = a_q;
  assign div_b_o     = b_q;
  assign wb_rd_o     = rd_q;
  assign wb_result_o = res_q;
  assign wb_pc_o     = pc_q;
  assign wb_inst_o   = inst_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - self-checking bench: cycle-timeline model of the divide sequencer plus literal pins
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_ready_o;
  logic [1:0]  req_op_i;
  logic [31:0] req_a_i, req_b_i, req_pc_i, req_inst_i;
  logic [4:0]  req_rd_i;
  logic        div_start_o;
  logic [1:0]  div_op_o;
  logic [31:0] div_a_o, div_b_o;
  logic        div_done_i;
  logic [31:0] div_result_i;
  logic        alu_slot_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_result_o, wb_pc_o, wb_inst_o;
  logic        stall_o, busy_o;
  logic [4:0]  busy_rd_o;
  logic        err_o;

  div_issue_ctrl #(.XLEN(32), .DIV_LATENCY(8), .MAX_WAIT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_rd_i(req_rd_i),
    .req_pc_i(req_pc_i), .req_inst_i(req_inst_i),
    .div_start_o(div_start_o), .div_op_o(div_op_o), .div_a_o(div_a_o), .div_b_o(div_b_o),
    .div_done_i(div_done_i), .div_result_i(div_result_i), .alu_slot_i(alu_slot_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_result_o(wb_result_o),
    .wb_pc_o(wb_pc_o), .wb_inst_o(wb_inst_o),
    .stall_o(stall_o), .busy_o(busy_o), .busy_rd_o(busy_rd_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  // Model timeline for the op in flight (cycle numbers, -10 = never)
  int          m_start = -10, m_wb = -10, m_busy_from = -10, m_busy_to = -11;
  int          m_err_from = -10, m_rst = -10;
  logic [31:0] m_res, m_pc, m_inst, m_a, m_b;
  logic [4:0]  m_rd;
  logic [1:0]  m_op;
  logic        err_m = 1'b0;

  int          wb_cnt = 0, last_wb_cyc = -1;
  logic [31:0] last_res = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00:   ref_div = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      2'b01:   ref_div = (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   ref_div = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: ref_div = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit fast_case(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_FASTPATH_EN
    fast_case = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`else
    fast_case = 1'b0;
`endif
  endfunction

  always @(negedge clk) begin
    bit busy_e;
    busy_e = (cyc >= m_busy_from) && (cyc <= m_busy_to);
    if (cyc == m_err_from) err_m = 1'b1;
    if (cyc == m_rst) err_m = 1'b0;
    chk("busy", busy_o, busy_e);
    chk("ready", req_ready_o, !busy_e);
    chk("stall", stall_o, busy_e | (req_valid_i & !busy_e));
    chk("start", div_start_o, cyc == m_start);
    chk("wb_valid", wb_valid_o, cyc == m_wb);
    chk("busy_rd", busy_rd_o, busy_e ? m_rd : 5'd0);
    chk("err", err_o, err_m);
    if (busy_e && m_start >= 0) begin
      chk("div_op", div_op_o, m_op);
      chk("div_a", div_a_o, m_a);
      chk("div_b", div_b_o, m_b);
    end
    if (wb_valid_o) begin
      wb_cnt++;
      last_wb_cyc = cyc;
      last_res = wb_result_o;
      chk("wb_result", wb_result_o, m_res);
      chk("wb_rd", wb_rd_o, m_rd);
      chk("wb_pc", wb_pc_o, m_pc);
      chk("wb_inst", wb_inst_o, m_inst);
    end
  end

  // lat: cycles from launch to done; hold: cycles alu_slot_i stays high once in HOLD;
  // never: divider never answers; rst_off: cycle offset from accept of a reset pulse (-1 none)
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int lat, input int hold, input bit never,
                        input int rst_off, output int t_acc);
    int T, D, H, W, R, endc;
    bit fast;
    logic [31:0] pc, inst;
    @(posedge clk); #1;
    T = cyc;
    t_acc = T;
    fast = fast_case(op, a, b);
    pc = $urandom;
    inst = $urandom;
    D = T + 1 + lat;
    if (fast) H = T + 1;
    else if (never) H = T + 18;
    else H = D + 1;
    W = H + hold;
    R = (rst_off >= 0) ? T + rst_off : -10;
    m_op = op; m_a = a; m_b = b; m_rd = rd; m_pc = pc; m_inst = inst;
    m_res = never ? 32'hFFFF_FFFF : ref_div(op, a, b);
    m_start = fast ? -10 : T + 1;
    m_busy_from = T + 1;
    m_busy_to = W;
    m_wb = W;
    m_err_from = (never && !fast) ? H : -10;
    m_rst = R;
    if (!fast && !never && rd == 0) begin
      m_busy_to = D;
      m_wb = -10;
    end
    if (R >= 0) begin
      m_busy_to = R - 1;
      m_wb = -10;
    end
    endc = ((m_busy_to > W) ? m_busy_to : W) + 2;
    for (int c = T; c <= endc; c++) begin
      req_valid_i = (c == T);
      req_op_i    = (c == T) ? op : 2'($urandom);
      req_a_i     = (c == T) ? a : $urandom;
      req_b_i     = (c == T) ? b : $urandom;
      req_rd_i    = (c == T) ? rd : 5'($urandom);
      req_pc_i    = (c == T) ? pc : $urandom;
      req_inst_i  = (c == T) ? inst : $urandom;
      alu_slot_i  = (c >= H) && (c < H + hold);
      div_done_i  = 1'b0;
      div_result_i = 32'h1234_5678;
      if (!fast && !never && c == D) begin
        div_done_i = 1'b1;
        div_result_i = ref_div(op, a, b);
      end
      if ((never && c == H) || c == endc) div_done_i = 1'b1;
      if (c == R) begin
        rst = 1'b0;
        #2;
        rst = 1'b1;
      end
      @(posedge clk); #1;
    end
    req_valid_i = 1'b0;
    div_done_i = 1'b0;
    alu_slot_i = 1'b0;
  endtask

  initial begin
    int t, n0;
    rst = 1'b0;
    req_valid_i = 1'b0; req_op_i = '0; req_a_i = '0; req_b_i = '0; req_rd_i = '0;
    req_pc_i = '0; req_inst_i = '0; div_done_i = 1'b0; div_result_i = '0; alu_slot_i = 1'b0;
    @(negedge clk);
    chk("rst_ready", req_ready_o, 1);
    chk("rst_wb", wb_valid_o, 0);
    chk("rst_busy_rd", busy_rd_o, 0);
    chk("rst_result", wb_result_o, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    run_op(2'b00, 32'd100, 32'd7, 5'd5, 8, 0, 0, -1, t);
    chk("div100_7", last_res, 32'd14);
    chk("div_lat", 32'(last_wb_cyc - t), 32'd10);

    run_op(2'b11, 32'd100, 32'd7, 5'd6, 8, 3, 0, -1, t);
    chk("remu100_7", last_res, 32'd2);
    chk("remu_hold_lat", 32'(last_wb_cyc - t), 32'd13);

    run_op(2'b01, 32'd55, 32'd0, 5'd7, 8, 0, 0, -1, t);
    chk("divu_zero", last_res, 32'hFFFF_FFFF);
`ifdef DIV_FASTPATH_EN
    chk("divu_zero_lat", 32'(last_wb_cyc - t), 32'd1);
`else
    chk("divu_zero_lat", 32'(last_wb_cyc - t), 32'd10);
`endif

    n0 = wb_cnt;
    run_op(2'b00, 32'd100, 32'd7, 5'd0, 5, 0, 0, -1, t);
    chk("rd0_no_wb", wb_cnt - n0, 0);

    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd9, 1, 0, 0, -1, t);
    chk("div_neg", last_res, 32'hFFFF_FFFD);

    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd10, 16, 0, 0, -1, t);
    chk("rem_last_cycle", last_res, 32'hFFFF_FFFF);
    chk("rem_last_err", err_o, 0);

    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 4, 0, 0, -1, t);
    chk("div_ovf", last_res, 32'h8000_0000);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 4, 0, 0, -1, t);
    chk("rem_ovf", last_res, 32'h0);

    run_op(2'b00, 32'd500, 32'd3, 5'd3, 0, 1, 1, -1, t);
    chk("wd_result", last_res, 32'hFFFF_FFFF);
    chk("wd_err", err_o, 1);
    chk("wd_lat", 32'(last_wb_cyc - t), 32'd19);

    n0 = wb_cnt;
    run_op(2'b01, 32'd900, 32'd9, 5'd13, 8, 0, 0, 4, t);
    chk("rst_no_wb", wb_cnt - n0, 0);
    chk("rst_err_clr", err_o, 0);
    chk("rst_busy_rd_mid", busy_rd_o, 0);

    run_op(2'b01, 32'hFFFF_FFFF, 32'd16, 5'd31, 3, 0, 0, -1, t);
    chk("divu_big", last_res, 32'h0FFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
